seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the 4-digit common-anode seven-segment display. It sequences the digit anodes from the 100 MHz master clock using internal clock-enable counting, with no derived clocks. It inserts a blanking gap between digits to suppress ghosting, and applies digit blinking. Display contents are double-buffered and committed only at frame boundaries, so a value written mid-scan never tears.

---
 rtl/seg_scan_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a 4-digit common-anode
// seven-segment display. A DRIVE/BLANK scan FSM runs from clock-enable counting
// on the master clock. Display contents are double-buffered (pending -> active)
// and committed only at frame boundaries, so updates never tear. All pin outputs
// are registered and lag the FSM state by one cycle.
module seg_scan_ctrl #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int BLINK_FRAMES = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  digit_en,
  input  logic [3:0]  blink_mask,
  input  logic        load,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  // One shared counter serves both DRIVE and BLANK, so size it for the longer one.
  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int BLK_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_FRAMES - 1);

  typedef enum logic {
    ST_DRIVE = 1'b0,
    ST_BLANK = 1'b1
  } state_t;

  // Scan FSM state
  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic              commit;

  // Blink state
  logic [BLK_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic              blink_phase_q, blink_phase_d;

  // Pending (written by load) and active (shown on the pins) buffers
  logic [15:0]       pend_value_q, pend_value_d;
  logic [3:0]        pend_dp_q, pend_dp_d;
  logic [3:0]        pend_en_q, pend_en_d;
  logic [3:0]        pend_mask_q, pend_mask_d;
  logic [15:0]       act_value_q, act_value_d;
  logic [3:0]        act_dp_q, act_dp_d;
  logic [3:0]        act_en_q, act_en_d;
  logic [3:0]        act_mask_q, act_mask_d;

  // Registered pin outputs
  logic [3:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic              frame_start_q, frame_start_d;

  // Per-digit helpers derived from the active buffer
  logic [3:0]        digit_visible;
  logic [3:0]        nibble [4];
  logic              lit;

  // Hex digit to active-low {g,f,e,d,c,b,a} segment pattern.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // A digit is visible when enabled and not suppressed by the blink off-phase.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      assign digit_visible[gi] = act_en_q[gi] & ~(act_mask_q[gi] & blink_phase_q);
      assign nibble[gi]        = act_value_q[4*gi +: 4];
    end
  endgenerate

  // Scan FSM next state: DRIVE for SCAN_DIV cycles, BLANK for BLANK_CYCLES, then next digit.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    scan_cnt_d = scan_cnt_q + 1'b1;
    commit     = 1'b0;
    case (state_q)
      ST_DRIVE: begin
        if (scan_cnt_q == SCAN_LAST) begin
          state_d    = ST_BLANK;
          scan_cnt_d = '0;
        end
      end
      ST_BLANK: begin
        if (scan_cnt_q == BLANK_LAST) begin
          state_d    = ST_DRIVE;
          scan_cnt_d = '0;
          idx_d      = idx_q + 2'd1;
          commit     = (idx_q == 2'd3);
        end
      end
      default: begin
        state_d    = ST_DRIVE;
        scan_cnt_d = '0;
      end
    endcase
  end

  // Double buffer: load fills pending; the frame boundary copies to active, bypassing a same-cycle load.
  always_comb begin
    pend_value_d = pend_value_q;
    pend_dp_d    = pend_dp_q;
    pend_en_d    = pend_en_q;
    pend_mask_d  = pend_mask_q;
    act_value_d  = act_value_q;
    act_dp_d     = act_dp_q;
    act_en_d     = act_en_q;
    act_mask_d   = act_mask_q;
    if (load) begin
      pend_value_d = value;
      pend_dp_d    = dp_in;
      pend_en_d    = digit_en;
      pend_mask_d  = blink_mask;
    end
    if (commit) begin
      if (load) begin
        act_value_d = value;
        act_dp_d    = dp_in;
        act_en_d    = digit_en;
        act_mask_d  = blink_mask;
      end else begin
        act_value_d = pend_value_q;
        act_dp_d    = pend_dp_q;
        act_en_d    = pend_en_q;
        act_mask_d  = pend_mask_q;
      end
    end
  end

  // Blink: count frames at each commit; toggle the phase every BLINK_FRAMES frames.
  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (commit) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Pin values for the current FSM cycle; registered below so pins lag by one cycle.
  always_comb begin
    lit           = (state_q == ST_DRIVE) && digit_visible[idx_q];
    an_d          = 4'hF;
    seg_d         = 7'h7F;
    dp_d          = 1'b1;
    frame_start_d = (state_q == ST_DRIVE) && (idx_q == 2'd0) && (scan_cnt_q == '0);
    if (lit) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = hex_to_seg(nibble[idx_q]);
      dp_d  = ~act_dp_q[idx_q];
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_DRIVE;
      idx_q         <= 2'd0;
      scan_cnt_q    <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      pend_value_q  <= '0;
      pend_dp_q     <= '0;
      pend_en_q     <= '0;
      pend_mask_q   <= '0;
      act_value_q   <= '0;
      act_dp_q      <= '0;
      act_en_q      <= '0;
      act_mask_q    <= '0;
      an_q          <= 4'hF;
      seg_q         <= 7'h7F;
      dp_q          <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      scan_cnt_q    <= scan_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      pend_value_q  <= pend_value_d;
      pend_dp_q     <= pend_dp_d;
      pend_en_q     <= pend_en_d;
      pend_mask_q   <= pend_mask_d;
      act_value_q   <= act_value_d;
      act_dp_q      <= act_dp_d;
      act_en_q      <= act_en_d;
      act_mask_q    <= act_mask_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl: directed scenarios followed by random loads and
// resets, every cycle checked against a frame-arithmetic reference model.
module tb_seg_scan_ctrl;
  localparam int SD    = 4;
  localparam int BC    = 2;
  localparam int BF    = 2;
  localparam int SLOT  = SD + BC;
  localparam int FRAME = 4 * SLOT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  digit_en = '0;
  logic [3:0]  blink_mask = '0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  seg_scan_ctrl #(
    .SCAN_DIV(SD),
    .BLANK_CYCLES(BC),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .value(value),
    .dp_in(dp_in),
    .digit_en(digit_en),
    .blink_mask(blink_mask),
    .load(load),
    .an(an),
    .seg(seg),
    .dp(dp),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: display buffers plus a cycle count since reset.
  logic [15:0] m_pend_val, m_act_val;
  logic [3:0]  m_pend_dp, m_act_dp, m_pend_en, m_act_en, m_pend_mask, m_act_mask;
  int          fsm_c;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp, exp_fs;
  logic [6:0]  hex_tbl [16];

  // Compare all four pins against the model.
  task automatic check_pins();
    n_assert++;
    assert (an === exp_an) else begin
      n_fail++;
      $error("FAIL an c=%0d observed=%b expected=%b", fsm_c, an, exp_an);
    end
    n_assert++;
    assert (seg === exp_seg) else begin
      n_fail++;
      $error("FAIL seg c=%0d observed=%h expected=%h", fsm_c, seg, exp_seg);
    end
    n_assert++;
    assert (dp === exp_dp) else begin
      n_fail++;
      $error("FAIL dp c=%0d observed=%b expected=%b", fsm_c, dp, exp_dp);
    end
    n_assert++;
    assert (frame_start === exp_fs) else begin
      n_fail++;
      $error("FAIL frame_start c=%0d observed=%b expected=%b", fsm_c, frame_start, exp_fs);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, check pins at the negedge.
  task automatic cycle(input bit r, input bit l, input logic [15:0] v,
                       input logic [3:0] d, input logic [3:0] e, input logic [3:0] m);
    int k, f, w, s, off;
    bit phase, on;
    rst = r; load = l; value = v; dp_in = d; digit_en = e; blink_mask = m;
    if (l) $display("load value=%h dp=%b en=%b mask=%b rst=%0b c=%0d", v, d, e, m, r, fsm_c);
    @(posedge clk);
    if (r) begin
      m_pend_val = '0; m_pend_dp = '0; m_pend_en = '0; m_pend_mask = '0;
      m_act_val  = '0; m_act_dp  = '0; m_act_en  = '0; m_act_mask  = '0;
      fsm_c = 0;
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fs = 1'b0;
    end else begin
      k     = fsm_c;
      f     = k / FRAME;
      w     = k % FRAME;
      s     = w / SLOT;
      off   = w % SLOT;
      phase = ((f / BF) % 2) == 1;
      on    = (off < SD) && m_act_en[s] && !(m_act_mask[s] && phase);
      exp_an  = on ? ~(4'b0001 << s) : 4'hF;
      exp_seg = on ? hex_tbl[m_act_val[4*s +: 4]] : 7'h7F;
      exp_dp  = on ? ~m_act_dp[s] : 1'b1;
      exp_fs  = (w == 0);
      if (w == FRAME - 1) begin
        if (l) begin
          m_act_val = v; m_act_dp = d; m_act_en = e; m_act_mask = m;
        end else begin
          m_act_val = m_pend_val; m_act_dp = m_pend_dp;
          m_act_en = m_pend_en; m_act_mask = m_pend_mask;
        end
      end
      if (l) begin
        m_pend_val = v; m_pend_dp = d; m_pend_en = e; m_pend_mask = m;
      end
      fsm_c++;
    end
    @(negedge clk);
    check_pins();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 4'h0);
  endtask

  initial begin
    hex_tbl[0]  = 7'h40; hex_tbl[1]  = 7'h79; hex_tbl[2]  = 7'h24; hex_tbl[3]  = 7'h30;
    hex_tbl[4]  = 7'h19; hex_tbl[5]  = 7'h12; hex_tbl[6]  = 7'h02; hex_tbl[7]  = 7'h78;
    hex_tbl[8]  = 7'h00; hex_tbl[9]  = 7'h10; hex_tbl[10] = 7'h08; hex_tbl[11] = 7'h03;
    hex_tbl[12] = 7'h46; hex_tbl[13] = 7'h21; hex_tbl[14] = 7'h06; hex_tbl[15] = 7'h0E;
    fsm_c = 0;

    // Reset held for three cycles, then a dark first frame.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 16'h0, 4'h0, 4'h0, 4'h0);
    idle(10);

    // Load mid-frame 0; it must appear only from frame 1.
    cycle(1'b0, 1'b1, 16'h12AF, 4'b0100, 4'b1111, 4'b0000);
    while (fsm_c < FRAME + 5) idle(1);

    // Tear-free: load zeros on cycle 5 of frame 1.
    cycle(1'b0, 1'b1, 16'h0000, 4'b0000, 4'b1111, 4'b0000);
    while (fsm_c < 3 * FRAME - 1) idle(1);

    // Commit bypass: load exactly in the commit cycle.
    cycle(1'b0, 1'b1, 16'h8888, 4'b0000, 4'b1111, 4'b0000);
    idle(1);
    n_assert++;
    assert (seg === 7'h00 && an === 4'b1110 && frame_start === 1'b1) else begin
      n_fail++;
      $error("FAIL bypass observed an=%b seg=%h fs=%b expected an=1110 seg=00 fs=1",
             an, seg, frame_start);
    end

    // Blink digit 0 for several frames.
    cycle(1'b0, 1'b1, 16'h4321, 4'b0000, 4'b1111, 4'b0001);
    idle(6 * FRAME);

    // Mid-scan reset while digit 2 is driven.
    while ((fsm_c % FRAME) != 2 * SLOT + 1) idle(1);
    cycle(1'b1, 1'b1, 16'hFFFF, 4'hF, 4'hF, 4'h0);
    n_assert++;
    assert (an === 4'hF && seg === 7'h7F && dp === 1'b1) else begin
      n_fail++;
      $error("FAIL midreset observed an=%b seg=%h dp=%b expected an=1111 seg=7f dp=1",
             an, seg, dp);
    end
    idle(2 * FRAME);

    // Random loads and occasional resets.
    for (int i = 0; i < 800; i++) begin
      cycle(($urandom_range(0, 149) == 0), ($urandom_range(0, 5) == 0),
            16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    end
    idle(FRAME);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
